// File: rtl/stage_4.sv
// rtl/stage_4.sv - RV32I memory-access stage with req/ack data port and access timeout
module stage_4 #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_alu_out,
    input  logic [31:0]       i_rs_2,
    input  logic [4:0]        i_rd_num,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_func_3,
    input  logic              i_op_type,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              o_valid,
    output logic              o_wb_en,
    output logic [4:0]        o_rd_num,
    output logic [31:0]       o_wb_data,
    output logic              o_misaligned,
    output logic              o_bus_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // Last ACCESS cycle count before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [31:0] addr_q;
    logic [2:0]  func_3_q;
    logic [4:0]  rd_q;
    logic        is_load_q;

    logic        is_load;
    logic        is_store;
    logic        func_ok;
    logic        aligned;
    logic        mem_ok;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign o_ready = (state == IDLE);

    // Decode the incoming memory operation: legality, alignment and store lanes.
    always_comb begin
        is_load  = (i_opcode == OP_LOAD);
        is_store = (i_opcode == OP_STORE);
        func_ok  = 1'b0;
        if (is_load) begin
            func_ok = (i_func_3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end else if (is_store) begin
            func_ok = (i_func_3 inside {3'd0, 3'd1, 3'd2});
        end
        case (i_func_3[1:0])
            2'b01:   aligned = ~i_alu_out[0];
            2'b10:   aligned = (i_alu_out[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        mem_ok = func_ok & aligned;
        case (i_func_3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_alu_out[1:0];
                st_wdata = {4{i_rs_2[7:0]}};
            end
            2'b01: begin
                st_be    = i_alu_out[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{i_rs_2[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = i_rs_2;
            end
        endcase
    end

    // Select and extend the loaded lane from the returned word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func_3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Stage sequencer: accept, run the bus access with timeout, present the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmo_cnt      <= 8'd0;
            addr_q       <= 32'd0;
            func_3_q     <= 3'd0;
            rd_q         <= 5'd0;
            is_load_q    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            o_valid      <= 1'b0;
            o_wb_en      <= 1'b0;
            o_rd_num     <= 5'd0;
            o_wb_data    <= 32'd0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        addr_q    <= i_alu_out;
                        func_3_q  <= i_func_3;
                        rd_q      <= i_rd_num;
                        is_load_q <= is_load;
                        if (!i_op_type) begin
                            o_valid      <= 1'b1;
                            o_wb_en      <= (i_rd_num != 5'd0);
                            o_rd_num     <= i_rd_num;
                            o_wb_data    <= i_alu_out;
                            o_misaligned <= 1'b0;
                            o_bus_err    <= 1'b0;
                            state        <= RESP;
                        end else if (!mem_ok) begin
                            // Faulting address is reported as the result for trap handling.
                            o_valid      <= 1'b1;
                            o_wb_en      <= 1'b0;
                            o_rd_num     <= i_rd_num;
                            o_wb_data    <= i_alu_out;
                            o_misaligned <= 1'b1;
                            o_bus_err    <= 1'b0;
                            state        <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= ADDR_W'({i_alu_out[31:2], 2'b00});
                            mem_be    <= is_store ? st_be : 4'd0;
                            mem_wdata <= is_store ? st_wdata : 32'd0;
                            tmo_cnt   <= 8'd0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        o_valid      <= 1'b1;
                        o_wb_en      <= is_load_q && (rd_q != 5'd0);
                        o_rd_num     <= rd_q;
                        o_wb_data    <= is_load_q ? ld_data : addr_q;
                        o_misaligned <= 1'b0;
                        o_bus_err    <= 1'b0;
                        state        <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req      <= 1'b0;
                        o_valid      <= 1'b1;
                        o_wb_en      <= 1'b0;
                        o_rd_num     <= rd_q;
                        o_wb_data    <= addr_q;
                        o_misaligned <= 1'b0;
                        o_bus_err    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_4.sv
// tb/tb_stage_4.sv - randomized and directed checks of stage_4 against a behavioural model
module tb_stage_4;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;
    localparam int         TMO   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_alu_out = '0;
    logic [31:0] i_rs_2 = '0;
    logic [4:0]  i_rd_num = '0;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_func_3 = '0;
    logic        i_op_type = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        o_valid;
    logic        o_wb_en;
    logic [4:0]  o_rd_num;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_err;

    int total = 0;
    int bad = 0;

    stage_4 #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_out(i_alu_out), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num),
        .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .o_valid(o_valid), .o_wb_en(o_wb_en), .o_rd_num(o_rd_num),
        .o_wb_data(o_wb_data), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one instruction; ack_at is the ACCESS cycle (1-based) carrying mem_ack, 0 = never.
    task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic op_t,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input int ack_at, input logic [31:0] rdata);
        bit          is_ld, is_st, legal, go_mem, tmo;
        int          bytes, lane, n_req;
        longint      w, m, span;
        logic [31:0] e_be, e_wd, e_val;
        is_ld  = (opc == LOAD);
        is_st  = (opc == STORE);
        legal  = is_ld ? !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (is_st ? (f3 <= 3'd2) : 1'b0);
        bytes  = 1 << f3[1:0];
        lane   = int'(alu[1:0]);
        go_mem = op_t && legal && ((lane % bytes) == 0);
        tmo    = !(ack_at >= 1 && ack_at <= TMO);
        n_req  = tmo ? TMO : ack_at;
        e_be   = is_st ? 32'((((1 << bytes) - 1) << lane) & 15) : 32'd0;
        e_wd   = (bytes == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                 (bytes == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
        w      = longint'(rdata) >> (8 * lane);
        if (bytes < 4) begin
            span = longint'(1) << (8 * bytes);
            m = w % span;
            if (!f3[2] && m >= span / 2) m = m - span;
        end else begin
            m = w;
        end
        e_val = m[31:0];

        @(negedge clk);
        i_valid = 1'b1; i_opcode = opc; i_func_3 = f3; i_op_type = op_t;
        i_alu_out = alu; i_rs_2 = rs2; i_rd_num = rd;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("ready_low_after_accept", 32'(o_ready), 32'd0);
        if (!go_mem) begin
            @(negedge clk);
            chk("direct_valid", 32'(o_valid), 32'd1);
            chk("direct_no_req", 32'(mem_req), 32'd0);
            chk("direct_misaligned", 32'(o_misaligned), 32'(op_t));
            chk("direct_bus_err", 32'(o_bus_err), 32'd0);
            chk("direct_wb_en", 32'(o_wb_en), 32'(!op_t && rd != 5'd0));
            chk("direct_rd", 32'(o_rd_num), 32'(rd));
            if (!op_t) chk("alu_wb_data", o_wb_data, alu);
        end else begin
            for (int c = 1; c <= n_req; c++) begin
                @(negedge clk);
                chk("req_high", 32'(mem_req), 32'd1);
                chk("valid_low_in_access", 32'(o_valid), 32'd0);
                chk("ready_low_in_access", 32'(o_ready), 32'd0);
                chk("mem_addr", mem_addr, alu & 32'hFFFF_FFFC);
                chk("mem_we", 32'(mem_we), 32'(is_st));
                chk("mem_be", 32'(mem_be), e_be);
                if (is_st) chk("mem_wdata", mem_wdata, e_wd);
                mem_ack   = (c == ack_at);
                mem_rdata = (c == ack_at) ? rdata : $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            chk("mem_valid", 32'(o_valid), 32'd1);
            chk("req_dropped", 32'(mem_req), 32'd0);
            chk("mem_bus_err", 32'(o_bus_err), 32'(tmo));
            chk("mem_misaligned", 32'(o_misaligned), 32'd0);
            chk("mem_wb_en", 32'(o_wb_en), 32'(is_ld && !tmo && rd != 5'd0));
            chk("mem_rd", 32'(o_rd_num), 32'(rd));
            if (is_ld && !tmo) chk("load_data", o_wb_data, e_val);
        end
        @(negedge clk);
        chk("valid_pulse_end", 32'(o_valid), 32'd0);
        chk("ready_back", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [6:0] opc;
        logic       opt;
        int         ack;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_flags", {30'd0, o_misaligned, o_bus_err}, 32'd0);
        rst_n = 1'b1;

        do_op(ALU,   3'd0, 1'b0, 32'h0000_1234, 32'h0,         5'd5, 0, 32'h0);
        do_op(LOAD,  3'd0, 1'b1, 32'h0000_0103, 32'h0,         5'd7, 3, 32'h80AA_BBCC);
        do_op(LOAD,  3'd4, 1'b1, 32'h0000_0103, 32'h0,         5'd7, 3, 32'h80AA_BBCC);
        do_op(STORE, 3'd1, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 1, 32'h0);
        do_op(LOAD,  3'd2, 1'b1, 32'h0000_0301, 32'h0,         5'd3, 1, 32'h0);
        do_op(LOAD,  3'd2, 1'b1, 32'h0000_0400, 32'h0,         5'd9, 0, 32'h0);
        do_op(LOAD,  3'd2, 1'b1, 32'h0000_0404, 32'h0,         5'd9, 4, 32'h1357_9BDF);
        do_op(LOAD,  3'd2, 1'b1, 32'h0000_0408, 32'h0,         5'd0, 1, 32'hCAFE_F00D);
        do_op(STORE, 3'd4, 1'b1, 32'h0000_0500, 32'h1,         5'd1, 1, 32'h0);
        do_op(LOAD,  3'd5, 1'b1, 32'h0000_0602, 32'h0,         5'd4, 2, 32'h8001_7FFF);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0:       begin opc = ALU;   opt = 1'b0; end
                1:       begin opc = LOAD;  opt = 1'b1; end
                default: begin opc = STORE; opt = 1'b1; end
            endcase
            ack = $urandom_range(0, TMO + 1);
            do_op(opc, 3'($urandom_range(0, 7)), opt, $urandom, $urandom,
                  5'($urandom_range(0, 31)), ack, $urandom);
        end

        @(negedge clk);
        i_valid = 1'b1; i_opcode = LOAD; i_func_3 = 3'd2; i_op_type = 1'b1;
        i_alu_out = 32'h0000_0700; i_rd_num = 5'd6;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(mem_req), 32'd0);
        chk("async_valid_low", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_reset_ready", 32'(o_ready), 32'd1);
            chk("post_reset_valid", 32'(o_valid), 32'd0);
            chk("post_reset_req", 32'(mem_req), 32'd0);
        end
        do_op(ALU, 3'd0, 1'b0, 32'h0000_00FF, 32'h0, 5'd0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
